// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and row-address helper for the
// character-LCD text controller (HD44780 command set).
package lcd_pkg;

  localparam logic [7:0] FUNC_SET  = 8'h38;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] DISP_CUR  = 8'h0F;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SET_ADDR,
    S_WRITE_CHAR,
    S_CURSOR
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_WAIT
  } tx_state_t;

  function automatic logic [7:0] row_addr(input logic [1:0] r);
    return ROW_BASE[r];
  endfunction

endpackage

// File: rtl/lcd_text_ctrl_byte_tx.sv
// Single-byte LCD bus timing engine: setup, EN pulse, post-EN wait.
// Ports: start/tx_data/tx_rs/long_wait in, done pulse, lcd_data/rs/en out.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int EN_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       tx_rs,
  input  logic       long_wait,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  tx_state_t   st;
  logic [31:0] cnt;
  logic        long_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= TX_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
    end else begin
      unique case (st)
        TX_IDLE: begin
          if (start) begin
            lcd_data <= tx_data;
            lcd_rs   <= tx_rs;
            long_q   <= long_wait;
            st       <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          cnt <= 32'(EN_PULSE_CYC - 1);
          st  <= TX_PULSE;
        end
        TX_PULSE: begin
          if (cnt == '0) begin
            cnt <= long_q ? 32'(CLR_WAIT_CYC - 1)
                          : 32'(CMD_WAIT_CYC - 1);
            st  <= TX_WAIT;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          if (cnt == '0) st <= TX_IDLE;
          else cnt <= cnt - 32'd1;
        end
      endcase
    end
  end

  // DATA/RS keep their value after EN falls until the next start
  assign lcd_en = (st == TX_PULSE);
  assign done   = (st == TX_WAIT) && (cnt == '0);

endmodule

// File: rtl/lcd_text_ctrl.sv
// ROWS x COLS text buffer + HD44780 init/refresh sequencer.
// Ports: clk, rst, wr_* host port, busy, LCD pins DATA/RW/EN/RS/ON. Option: LCD_CURSOR_EN.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int ROWS           = 2,
  parameter int COLS           = 16,
  parameter int EN_PULSE_CYC   = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLR_WAIT_CYC   = 100000,
  parameter int PWRUP_WAIT_CYC = 1000000,
  localparam int RW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [RW_W-1:0] wr_row,
  input  logic [CW_W-1:0] wr_col,
  input  logic [7:0]      wr_char,
  output logic            busy,
  output logic [7:0]      DATA,
  output logic            RW,
  output logic            EN,
  output logic            RS,
  output logic            ON
);

  localparam logic [RW_W:0]   ROWS_L   = (RW_W+1)'(ROWS);
  localparam logic [CW_W:0]   COLS_L   = (CW_W+1)'(COLS);
  localparam logic [RW_W-1:0] ROW_LAST = RW_W'(ROWS - 1);
  localparam logic [CW_W-1:0] COL_LAST = CW_W'(COLS - 1);
  localparam logic [31:0]     PW_LAST  = 32'(PWRUP_WAIT_CYC - 1);

  state_t          state, state_n;
  logic [31:0]     pw_cnt;
  logic [1:0]      init_idx;
  logic [RW_W-1:0] row_q;
  logic [CW_W-1:0] col_q;
  logic            dirty;
  logic            issued;
  logic            on_q;
  logic [7:0]      char_buf [ROWS][COLS];

  logic       tx_start, tx_rs, tx_long, tx_done;
  logic [7:0] tx_byte;
  logic       wr_ok, col_last, row_last;

`ifdef LCD_CURSOR_EN
  logic [RW_W-1:0] cur_row;
  logic [CW_W-1:0] cur_col;
`endif

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    unique case (i)
      2'd0:    c = FUNC_SET;
`ifdef LCD_CURSOR_EN
      2'd1:    c = DISP_CUR;
`else
      2'd1:    c = DISP_ON;
`endif
      2'd2:    c = ENTRY;
      default: c = CLEAR;
    endcase
    return c;
  endfunction

  assign wr_ok = wr_en
              && ({1'b0, wr_row} < ROWS_L)
              && ({1'b0, wr_col} < COLS_L);
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_PWRUP;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    tx_rs    = 1'b0;
    tx_long  = 1'b0;
    unique case (state)
      S_PWRUP: begin
        if (pw_cnt == PW_LAST) state_n = S_INIT;
      end
      S_INIT: begin
        tx_byte  = init_cmd(init_idx);
        tx_long  = (tx_byte == CLEAR);
        tx_start = !issued;
        if (tx_done && init_idx == 2'd3) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (dirty) state_n = S_SET_ADDR;
      end
      S_SET_ADDR: begin
        tx_byte  = SET_DDRAM | row_addr(2'(row_q));
        tx_start = !issued;
        if (tx_done) state_n = S_WRITE_CHAR;
      end
      S_WRITE_CHAR: begin
        tx_byte  = char_buf[row_q][col_q];
        tx_rs    = 1'b1;
        tx_start = !issued;
        if (tx_done && col_last) begin
          if (!row_last) state_n = S_SET_ADDR;
`ifdef LCD_CURSOR_EN
          else state_n = S_CURSOR;
`else
          else state_n = S_IDLE;
`endif
        end
      end
`ifdef LCD_CURSOR_EN
      S_CURSOR: begin
        tx_byte  = SET_DDRAM
                 | (row_addr(2'(cur_row)) + 8'(cur_col));
        tx_start = !issued;
        if (tx_done) state_n = S_IDLE;
      end
`endif
      default: state_n = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pw_cnt   <= '0;
      init_idx <= '0;
      row_q    <= '0;
      col_q    <= '0;
      dirty    <= 1'b1;
      issued   <= 1'b0;
      on_q     <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          char_buf[r][c] <= 8'h20;
`ifdef LCD_CURSOR_EN
      cur_row <= '0;
      cur_col <= '0;
`endif
    end else begin
      on_q <= 1'b1;
      if (state == S_PWRUP) pw_cnt <= pw_cnt + 32'd1;
      if (tx_start) issued <= 1'b1;
      if (tx_done)  issued <= 1'b0;
      if (state == S_INIT && tx_done)
        init_idx <= init_idx + 2'd1;
      if (state == S_IDLE && dirty) begin
        dirty <= 1'b0;
        row_q <= '0;
      end
      if (state == S_SET_ADDR && tx_done) col_q <= '0;
      if (state == S_WRITE_CHAR && tx_done) begin
        if (!col_last)     col_q <= col_q + CW_W'(1);
        else if (!row_last) row_q <= row_q + RW_W'(1);
      end
      // a host write landing on the clearing edge keeps dirty set
      if (wr_ok) begin
        char_buf[wr_row][wr_col] <= wr_char;
        dirty <= 1'b1;
`ifdef LCD_CURSOR_EN
        if (wr_col == COL_LAST) begin
          cur_col <= '0;
          cur_row <= (wr_row == ROW_LAST) ? '0 : wr_row + RW_W'(1);
        end else begin
          cur_col <= wr_col + CW_W'(1);
          cur_row <= wr_row;
        end
`endif
      end
    end
  end

  lcd_byte_tx #(
    .EN_PULSE_CYC (EN_PULSE_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (tx_start),
    .tx_data   (tx_byte),
    .tx_rs     (tx_rs),
    .long_wait (tx_long),
    .done      (tx_done),
    .lcd_data  (DATA),
    .lcd_rs    (RS),
    .lcd_en    (EN)
  );

  assign busy = !(state == S_IDLE && !dirty);
  assign RW   = 1'b0;
  assign ON   = on_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Testbench for lcd_text_ctrl: 2x16 and 4x20 instances, bus-byte scoreboards.
// Honours LCD_CURSOR_EN when defined for the build.
module tb_lcd_text_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2x16 instance
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [0:0] wr_row = '0;
  logic [3:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       busy, RW, EN, RS, ON;
  logic [7:0] DATA;

  // 4x20 instance
  logic       rst4 = 1'b1;
  logic       wr_en4 = 1'b0;
  logic [1:0] wr_row4 = '0;
  logic [4:0] wr_col4 = '0;
  logic [7:0] wr_char4 = '0;
  logic       busy4, RW4, EN4, RS4, ON4;
  logic [7:0] DATA4;

  lcd_text_ctrl #(
    .ROWS(2), .COLS(16), .EN_PULSE_CYC(2), .CMD_WAIT_CYC(4),
    .CLR_WAIT_CYC(8), .PWRUP_WAIT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_char(wr_char), .busy(busy),
    .DATA(DATA), .RW(RW), .EN(EN), .RS(RS), .ON(ON)
  );

  lcd_text_ctrl #(
    .ROWS(4), .COLS(20), .EN_PULSE_CYC(2), .CMD_WAIT_CYC(4),
    .CLR_WAIT_CYC(8), .PWRUP_WAIT_CYC(16)
  ) dut4 (
    .clk(clk), .rst(rst4), .wr_en(wr_en4), .wr_row(wr_row4),
    .wr_col(wr_col4), .wr_char(wr_char4), .busy(busy4),
    .DATA(DATA4), .RW(RW4), .EN(EN4), .RS(RS4), .ON(ON4)
  );

  logic [8:0] sb2[$];
  logic [8:0] sb4[$];
  logic [7:0] m2 [2][16];
  logic [7:0] m4 [4][20];
  int cr2 = 0, cc2 = 0, cr4 = 0, cc4 = 0;
  logic [7:0] base_tb [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  // bus monitors: pop expected {RS,DATA} on each EN rise
  logic e2 = 1'b0, e4 = 1'b0;
  int   w2 = 0, w4 = 0;
  logic [8:0] got2, exp2, got4, exp4;

  always @(negedge clk) begin
    if (rst) begin
      e2 = 1'b0; w2 = 0;
    end else begin
      if (EN && !e2) begin
        got2 = {RS, DATA};
        checks++;
        if (sb2.size() == 0) begin
          errors++;
          $display("FAIL bus2 unexpected byte got=%h", got2);
        end else begin
          exp2 = sb2.pop_front();
          if (got2 !== exp2) begin
            errors++;
            $display("FAIL bus2 byte got=%h exp=%h", got2, exp2);
          end
        end
      end
      if (EN) w2++;
      if (!EN && e2) begin
        checks++;
        if (w2 != 2) begin
          errors++;
          $display("FAIL en2_width got=%0d exp=2", w2);
        end
        w2 = 0;
      end
      e2 = EN;
    end
  end

  always @(negedge clk) begin
    if (rst4) begin
      e4 = 1'b0; w4 = 0;
    end else begin
      if (EN4 && !e4) begin
        got4 = {RS4, DATA4};
        checks++;
        if (sb4.size() == 0) begin
          errors++;
          $display("FAIL bus4 unexpected byte got=%h", got4);
        end else begin
          exp4 = sb4.pop_front();
          if (got4 !== exp4) begin
            errors++;
            $display("FAIL bus4 byte got=%h exp=%h", got4, exp4);
          end
        end
      end
      if (EN4) w4++;
      if (!EN4 && e4) begin
        checks++;
        if (w4 != 2) begin
          errors++;
          $display("FAIL en4_width got=%0d exp=2", w4);
        end
        w4 = 0;
      end
      e4 = EN4;
    end
  end

  task automatic push(input bit big, input logic [8:0] v);
    if (big) sb4.push_back(v);
    else     sb2.push_back(v);
  endtask

  task automatic clear_model(input bit big);
    if (big) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 20; c++) m4[r][c] = 8'h20;
      cr4 = 0; cc4 = 0;
    end else begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 16; c++) m2[r][c] = 8'h20;
      cr2 = 0; cc2 = 0;
    end
  endtask

  task automatic push_init(input bit big);
    push(big, {1'b0, 8'h38});
`ifdef LCD_CURSOR_EN
    push(big, {1'b0, 8'h0F});
`else
    push(big, {1'b0, 8'h0C});
`endif
    push(big, {1'b0, 8'h06});
    push(big, {1'b0, 8'h01});
  endtask

  task automatic push_tail(input bit big);
`ifdef LCD_CURSOR_EN
    if (big) push(big, {1'b0, 8'h80 | (base_tb[cr4] + 8'(cc4))});
    else     push(big, {1'b0, 8'h80 | (base_tb[cr2] + 8'(cc2))});
`else
    if (big) sb4 = sb4;
`endif
  endtask

  task automatic push_frame(input bit big, input bit tail);
    int rows, cols;
    rows = big ? 4 : 2;
    cols = big ? 20 : 16;
    for (int r = 0; r < rows; r++) begin
      push(big, {1'b0, 8'h80 | base_tb[r]});
      for (int c = 0; c < cols; c++)
        push(big, {1'b1, big ? m4[r][c] : m2[r][c]});
    end
    if (tail) push_tail(big);
  endtask

  task automatic do_write(input bit big, input int r, input int c,
                          input logic [7:0] ch);
    int rows, cols, nr, nc;
    rows = big ? 4 : 2;
    cols = big ? 20 : 16;
    if (r < rows && c < cols) begin
      if (c == cols - 1) begin
        nc = 0;
        nr = (r == rows - 1) ? 0 : r + 1;
      end else begin
        nc = c + 1;
        nr = r;
      end
      if (big) begin m4[r][c] = ch; cr4 = nr; cc4 = nc; end
      else     begin m2[r][c] = ch; cr2 = nr; cc2 = nc; end
    end
    @(negedge clk);
    if (big) begin
      wr_en4 = 1'b1; wr_row4 = 2'(r); wr_col4 = 5'(c); wr_char4 = ch;
    end else begin
      wr_en = 1'b1; wr_row = 1'(r); wr_col = 4'(c); wr_char = ch;
    end
    @(negedge clk);
    wr_en  = 1'b0;
    wr_en4 = 1'b0;
  endtask

  task automatic wait_idle(input bit big, input int budget,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((big ? busy4 : busy) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst = 1'b1; rst4 = 1'b1;
    clear_model(0); clear_model(1);
    repeat (3) @(negedge clk);
    checks++;
    if ({EN, ON, busy, RS, RW} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=00100", {EN, ON, busy, RS, RW});
    end
    checks++;
    if (DATA !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got=%h exp=00", DATA);
    end
    checks++;
    if ({EN4, ON4, busy4} !== 3'b001) begin
      errors++;
      $display("FAIL reset4_ctl got=%b exp=001", {EN4, ON4, busy4});
    end
    push_init(0); push_frame(0, 1);
    push_init(1); push_frame(1, 1);
    rst = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ON, busy, RW} !== 3'b110) begin
      errors++;
      $display("FAIL on_after_rst got=%b exp=110", {ON, busy, RW});
    end
    wait_idle(0, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL init2_idle got=busy exp=idle");
    end
    checks++;
    if (sb2.size() != 0) begin
      errors++;
      $display("FAIL init2_drain got=%0d exp=0", sb2.size());
    end
    wait_idle(1, 3000, ok);
    checks++;
    if (!ok || sb4.size() != 0) begin
      errors++;
      $display("FAIL init4 got=ok%0d left%0d exp=ok1 left0",
               ok, sb4.size());
    end
  endtask

  task automatic test_write_idle;
    bit ok;
    do_write(0, 1, 3, 8'h41);
    push_frame(0, 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise got=%b exp=1", busy);
    end
    wait_idle(0, 2000, ok);
    checks++;
    if (!ok || sb2.size() != 0) begin
      errors++;
      $display("FAIL write_idle got=ok%0d left%0d exp=ok1 left0",
               ok, sb2.size());
    end
  endtask

  task automatic test_write_during_refresh;
    bit ok, hit;
    do_write(0, 1, 5, 8'h31);
    push_frame(0, 0);
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sb2.size() <= 8) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_refresh got=hit%0d busy%b exp=hit1 busy1",
               hit, busy);
    end
    do_write(0, 0, 0, 8'h5A);
    push_tail(0);
    push_frame(0, 1);
    wait_idle(0, 3000, ok);
    checks++;
    if (!ok || sb2.size() != 0) begin
      errors++;
      $display("FAIL second_pass got=ok%0d left%0d exp=ok1 left0",
               ok, sb2.size());
    end
  endtask

  task automatic test_rst_mid_pulse;
    bit ok, hit;
    do_write(0, 0, 1, 8'h42);
    push_frame(0, 1);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (EN) begin hit = 1'b1; break; end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!hit || {EN, ON, busy} !== 3'b001) begin
      errors++;
      $display("FAIL rst_mid got=hit%0d %b exp=hit1 001",
               hit, {EN, ON, busy});
    end
    checks++;
    if (DATA !== 8'h00 || RS !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_bus got=%h/%b exp=00/0", DATA, RS);
    end
    sb2.delete();
    clear_model(0);
    push_init(0); push_frame(0, 1);
    rst = 1'b0;
    wait_idle(0, 3000, ok);
    checks++;
    if (!ok || sb2.size() != 0) begin
      errors++;
      $display("FAIL restart got=ok%0d left%0d exp=ok1 left0",
               ok, sb2.size());
    end
  endtask

  task automatic test_ignored4;
    bit seen;
    do_write(1, 0, 20, 8'h41);
    do_write(1, 3, 31, 8'h42);
    do_write(1, 2, 25, 8'h43);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy4) seen = 1'b1;
    end
    checks++;
    if (seen || sb4.size() != 0) begin
      errors++;
      $display("FAIL ignored got=busy%0d exp=busy0", seen);
    end
  endtask

  task automatic test_cursor4;
    bit ok;
    do_write(1, 3, 19, 8'h5A);
    push_frame(1, 1);
    wait_idle(1, 3000, ok);
    checks++;
    if (!ok || sb4.size() != 0) begin
      errors++;
      $display("FAIL last_cell got=ok%0d left%0d exp=ok1 left0",
               ok, sb4.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_idle();
    test_write_during_refresh();
    test_rst_mid_pulse();
    test_ignored4();
    test_cursor4();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
